// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported unified memory
//
// Purpose: shares one memory port between instruction fetch (reads only) and
// the mem_access stage (loads/stores). One transaction is outstanding at a
// time. Data wins simultaneous requests, but never more than MAX_DATA_STREAK
// times in a row while fetch is waiting. Branch flushes swallow the fetch
// response that is still in flight.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req_i/if_addr_i/if_flush_i   fetch request, address, response discard
//   if_gnt_o/if_rvalid_o/if_rdata_o fetch grant, read data valid, read data
//   d_req_i/d_we_i/d_addr_i/
//   d_wdata_i/d_be_i                data request, store flag, address, data, byte enables
//   d_gnt_o/d_rvalid_o/d_rdata_o    data grant, load data / store ack, load data
//   mem_req_o/mem_we_o/mem_addr_o/
//   mem_wdata_o/mem_be_o            memory request and its registered fields
//   mem_ready_i/mem_rvalid_i/
//   mem_rdata_i                     memory accept, response valid, read data
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  state_t        state, state_nxt;
  owner_t        owner;
  logic [SW-1:0] streak;
  logic          flush_pending;
  logic          arb_en;
  logic          grant_f;
  logic          grant_d;
  logic          resp;
  logic          if_rvalid;
  logic          d_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    resp      = 1'b0;
    mem_req_o = 1'b0;
    case (state)
      IDLE:  arb_en = 1'b1;
      ISSUE: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) state_nxt = WAIT;
      end
      WAIT: begin
        // The response cycle doubles as an arbitration slot so back-to-back
        // transactions need no IDLE bubble.
        if (mem_rvalid_i) begin
          resp      = 1'b1;
          arb_en    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // rst_n gating keeps grants low while reset is held even though the
    // requesters may still be asserting.
    if (arb_en && rst_n) begin
      if (d_req_i && !(if_req_i && streak == STREAK_MAX)) grant_d = 1'b1;
      else if (if_req_i)                                  grant_f = 1'b1;
    end
    if (grant_d || grant_f) state_nxt = ISSUE;

    if_rvalid   = resp && (owner == OWN_FETCH) && !flush_pending && !if_flush_i;
    d_rvalid    = resp && (owner == OWN_DATA);
    if_gnt_o    = grant_f;
    d_gnt_o     = grant_d;
    if_rvalid_o = if_rvalid;
    d_rvalid_o  = d_rvalid;
    if_rdata_o  = if_rvalid ? mem_rdata_i : 32'h0;
    // mem_we_o still holds the owner's direction in its response cycle.
    d_rdata_o   = (d_rvalid && !mem_we_o) ? mem_rdata_i : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner         <= OWN_NONE;
      streak        <= '0;
      flush_pending <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= 32'h0;
      mem_be_o      <= 4'h0;
    end else begin
      if (grant_d) begin
        owner       <= OWN_DATA;
        mem_we_o    <= d_we_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
        mem_be_o    <= d_be_i;
        // Only data grants that made fetch wait count toward the streak.
        if (!if_req_i)                streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + SW'(1);
      end else if (grant_f) begin
        owner       <= OWN_FETCH;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= 32'h0;
        mem_be_o    <= 4'hF;
        streak      <= '0;
      end else if (resp) begin
        owner       <= OWN_NONE;
      end

      if (resp)
        flush_pending <= 1'b0;
      else if (if_flush_i && owner == OWN_FETCH && (state == ISSUE || state == WAIT))
        flush_pending <= 1'b1;
    end
  end

endmodule
